mtm_alu_serializer: RTL

//  Output side of mtm_Alu: turns one ALU result into the serial response on sout.

---
 rtl/mtm_alu_serializer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mtm_alu_serializer.sv
// rtl/mtm_alu_serializer.sv - mtm_Alu response serializer: 4 data frames + CRC control frame, or 1 error frame
module mtm_alu_serializer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_err,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_flags,
    input  logic [5:0]  in_err_flags,
    output logic        sout,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, START, CMD, DATA, STOP} state_t;

    localparam int            CW          = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] CYC_LAST    = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CYC_PRELAST = CW'(BIT_CYCLES - 2);
    localparam logic          ONE_CYCLE   = (BIT_CYCLES == 1);

    state_t        state_q;
    logic [CW-1:0] cyc_q;
    logic [2:0]    bit_q;
    logic [2:0]    frame_q;
    logic          err_q;
    logic [31:0]   data_q;
    logic [3:0]    flags_q;
    logic [5:0]    err_flags_q;
    logic          sout_q;

    logic [2:0]    crc;
    logic [7:0]    payload;
    logic          ctrl_frame;
    logic          last_cyc;

    // CRC x^3+x+1, init 0, MSB first over {C, 0, FLAGS}
    function automatic logic [2:0] crc3(input logic [36:0] v);
        logic [2:0] c;
        logic       fb;
        c = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb = c[2] ^ v[i];
            c  = {c[1], c[0] ^ fb, fb};
        end
        return c;
    endfunction

    assign crc        = crc3({data_q, 1'b0, flags_q});
    // The control frame (error frame or frame 4) is always the last frame of a response.
    assign ctrl_frame = err_q | (frame_q == 3'd4);
    assign last_cyc   = (cyc_q == CYC_LAST);

    // Payload byte of the frame currently being sent
    always_comb begin
        payload = 8'h00;
        if (err_q) begin
            payload = {1'b1, err_flags_q, ^{1'b1, err_flags_q}};
        end else begin
            case (frame_q)
                3'd0:    payload = data_q[31:24];
                3'd1:    payload = data_q[23:16];
                3'd2:    payload = data_q[15:8];
                3'd3:    payload = data_q[7:0];
                default: payload = {1'b0, flags_q, crc};
            endcase
        end
    end

    // Frame/bit sequencer with registered serial output. The FSM drops to IDLE
    // for the final cycle of the last stop bit (sout is already 1 there), so a
    // request presented then starts its frame with no idle gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cyc_q       <= '0;
            bit_q       <= 3'd0;
            frame_q     <= 3'd0;
            err_q       <= 1'b0;
            data_q      <= 32'h0;
            flags_q     <= 4'h0;
            err_flags_q <= 6'h0;
            sout_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    cyc_q <= '0;
                    if (in_valid) begin
                        err_q       <= in_err;
                        data_q      <= in_data;
                        flags_q     <= in_flags;
                        err_flags_q <= in_err_flags;
                        frame_q     <= 3'd0;
                        state_q     <= START;
                        sout_q      <= 1'b0;
                    end else begin
                        sout_q      <= 1'b1;
                    end
                end
                default: begin
                    if (!last_cyc) begin
                        cyc_q <= cyc_q + 1'b1;
                        if (state_q == STOP && ctrl_frame && cyc_q == CYC_PRELAST) begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cyc_q <= '0;
                        case (state_q)
                            START: begin
                                state_q <= CMD;
                                sout_q  <= ctrl_frame;
                            end
                            CMD: begin
                                state_q <= DATA;
                                bit_q   <= 3'd7;
                                sout_q  <= payload[7];
                            end
                            DATA: begin
                                if (bit_q != 3'd0) begin
                                    bit_q  <= bit_q - 1'b1;
                                    sout_q <= payload[bit_q - 1'b1];
                                end else begin
                                    state_q <= (ctrl_frame && ONE_CYCLE) ? IDLE : STOP;
                                    sout_q  <= 1'b1;
                                end
                            end
                            STOP: begin
                                state_q <= START;
                                frame_q <= frame_q + 1'b1;
                                sout_q  <= 1'b0;
                            end
                            default: begin
                                state_q <= IDLE;
                                sout_q  <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign sout     = sout_q;
    assign in_ready = (state_q == IDLE);
    assign busy     = ~in_ready;

endmodule
